// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU response checker.
// Build option ALU_RESP_CHK_MASK_EN adds a per-vector compare mask to each delay-line slot.
package alu_chk_pkg;

    localparam int          MAX_LATENCY = 8;
    localparam int          DATA_W      = 64;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chk_state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
`ifdef ALU_RESP_CHK_MASK_EN
        logic [DATA_W-1:0] mask;
`endif
    } chk_slot_t;

endpackage

// File: rtl/alu_resp_checker_if.sv
// Stimulus/result bundle between a vector source and alu_resp_checker.
// Build option ALU_RESP_CHK_MASK_EN adds issue_mask (1 = bit compared).
interface alu_resp_checker_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             stop;
    logic             issue_vld;
    logic [WIDTH-1:0] issue_exp;
`ifdef ALU_RESP_CHK_MASK_EN
    logic [WIDTH-1:0] issue_mask;
`endif
    logic             issue_rdy;
    logic [WIDTH-1:0] alu_byp_rd_data_e;
    logic             busy;
    logic             done;
    logic             err_flag;
    logic [31:0]      vec_cnt;
    logic [15:0]      err_cnt;
    logic [31:0]      first_err_idx;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_act;

    modport master (
        output start, stop, issue_vld,
`ifdef ALU_RESP_CHK_MASK_EN
               issue_mask,
`endif
               issue_exp, alu_byp_rd_data_e,
        input  issue_rdy, busy, done, err_flag, vec_cnt, err_cnt,
               first_err_idx, first_err_exp, first_err_act
    );

    modport slave (
        input  start, stop, issue_vld,
`ifdef ALU_RESP_CHK_MASK_EN
               issue_mask,
`endif
               issue_exp, alu_byp_rd_data_e,
        output issue_rdy, busy, done, err_flag, vec_cnt, err_cnt,
               first_err_idx, first_err_exp, first_err_act
    );

endinterface

// File: rtl/alu_chk_dly.sv
// LATENCY-stage shift register of expectation slots, with synchronous active-low flush.
// pending_o reports whether any slot still carries an uncompared vector.
module alu_chk_dly
    import alu_chk_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      rclk,
    input  logic      flush_l_i,
    input  chk_slot_t slot_i,
    output chk_slot_t slot_o,
    output logic      pending_o
);

    localparam int DEPTH = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                           (LATENCY < 1)           ? 1 : LATENCY;

    chk_slot_t stage_q [DEPTH];

    // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
    // NOTE: only the valid bits are flushed; exp/mask are don't-care while valid is low.
    always_ff @(posedge rclk) begin
        if (!flush_l_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else begin
            stage_q[0] <= slot_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign slot_o = stage_q[DEPTH-1];

    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_o = pending_o | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Delays each issued expectation by LATENCY cycles, compares it with the ALU bypass result and
// keeps pass/fail statistics. Build option ALU_RESP_CHK_MASK_EN enables per-vector bit masking.
module alu_resp_checker
    import alu_chk_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 64
) (
    input  logic              rclk,
    input  logic              rst_l,
    alu_resp_checker_if.slave bus
);

    chk_state_t       state_q, state_d;
    logic             issue_rdy, busy;
    logic             accept, pending, start_clr, mismatch;
    chk_slot_t        push_slot, head_slot;
    logic [WIDTH-1:0] cmp_mask;

    logic             done_q, done_d;
    logic             err_flag_q, err_flag_d;
    logic [31:0]      vec_cnt_q, vec_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [31:0]      first_idx_q, first_idx_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_act_q, first_act_d;

    always_ff @(posedge rclk) begin
        if (!rst_l) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (bus.stop)  state_d = ST_DRAIN;
            ST_DRAIN: if (!pending)  state_d = ST_DONE;
            ST_DONE:  if (bus.start) state_d = ST_RUN;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_rdy = (state_q == ST_RUN);
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    end

    assign accept    = bus.issue_vld && issue_rdy;
    assign start_clr = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign done_d    = (state_q == ST_DRAIN) && (state_d == ST_DONE);

    always_comb begin
        push_slot       = '0;
        push_slot.valid = accept;
        push_slot.exp   = bus.issue_exp;
`ifdef ALU_RESP_CHK_MASK_EN
        push_slot.mask  = bus.issue_mask;
`endif
    end

    alu_chk_dly #(.LATENCY(LATENCY)) u_dly (
        .rclk      (rclk),
        .flush_l_i (rst_l),
        .slot_i    (push_slot),
        .slot_o    (head_slot),
        .pending_o (pending)
    );

`ifdef ALU_RESP_CHK_MASK_EN
    assign cmp_mask = head_slot.mask;
`else
    assign cmp_mask = '1;
`endif

    assign mismatch = |((bus.alu_byp_rd_data_e ^ head_slot.exp) & cmp_mask);

    // Statistics; start in IDLE/DONE wins because the delay line is empty there anyway.
    always_comb begin
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_idx_d = first_idx_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        if (start_clr) begin
            vec_cnt_d   = '0;
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_idx_d = '0;
            first_exp_d = '0;
            first_act_d = '0;
        end else if (head_slot.valid) begin
            vec_cnt_d = vec_cnt_q + 32'd1;
            if (mismatch) begin
                if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 16'd1;
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_idx_d = vec_cnt_q;
                    first_exp_d = head_slot.exp & cmp_mask;
                    first_act_d = bus.alu_byp_rd_data_e;
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    assign bus.issue_rdy     = issue_rdy;
    assign bus.busy          = busy;
    assign bus.done          = done_q;
    assign bus.err_flag      = err_flag_q;
    assign bus.vec_cnt       = vec_cnt_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_idx_q;
    assign bus.first_err_exp = first_exp_q;
    assign bus.first_err_act = first_act_q;

endmodule
